alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 Port: A  input  WIDTH  operand A; sampled on acceptance only.
REQ-007 Port: B  input  WIDTH  operand B; sampled on acceptance only.
REQ-008 Port: ALUctr  input  4  opcode; sampled on acceptance only.
REQ-009 Port: out_valid  output  1  result registers hold a completed result.
REQ-010 Port: out_ready  input  1  consumer takes the result.
REQ-011 Port: Res  output  WIDTH  primary result (sum, logic result, compare bit, product low half, quotient).
REQ-012 Port: Hi  output  WIDTH  product high half or remainder; 0 for single-cycle ops.
REQ-013 Port: Zero  output  1  Res == 0.
REQ-014 Port: Overfl  output  1  signed overflow, opcodes 0000/0010 only.
REQ-015 Port: DivZero  output  1  divide with B == 0.

Function
REQ-016 Acceptance: rising edge with in_valid && in_ready; A, B, ALUctr latched internally; input changes thereafter ignored.
REQ-017 States: IDLE, BUSY, DONE. IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting mul/div; BUSY->DONE after exactly WIDTH iteration cycles; DONE->IDLE on out_valid && out_ready.
REQ-018 out_valid high only in DONE; Res/Hi/flags stable throughout DONE regardless of out_ready duration.
REQ-019 Single-cycle latency: out_valid high from first edge after acceptance; mul/div: out_valid high WIDTH+1 edges after acceptance.
REQ-020 Opcodes: 0000 add (Overfl checked), 0001 addu, 0010 sub (Overfl checked), 0011 subu, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt signed, 1011 sltu unsigned; all wrap modulo 2^WIDTH, Hi = 0.
REQ-021 Compare ops: Res = {WIDTH-1 zeros, lt}; slt compares two's complement, sltu unsigned.
REQ-022 Opcodes 1100 mulu, 1101 mul signed: 2*WIDTH-bit product, {Hi,Res}; one shift-add step per BUSY cycle.
REQ-023 Opcodes 1110 divu, 1111 div signed: Res = quotient truncated toward zero, Hi = remainder with sign of A; one restoring step per BUSY cycle.
REQ-024 Divide by zero (B == 0): Res = all ones, Hi = A, DivZero = 1; still occupies full WIDTH+1 latency.
REQ-025 Signed div MIN / -1: Res = MIN (0x80..0), Hi = 0, Overfl = 0, DivZero = 0.
REQ-026 Opcodes 1000, 1001: single-cycle, Res = 0, Hi = 0, Zero = 1, other flags 0.
REQ-027 Overfl = 1 only for 0000/0010 when operand signs produce a sign-inconsistent result; 0 for all other opcodes.
REQ-028 Zero derived from final Res for every opcode including mul/div.
REQ-029 in_valid while BUSY or DONE: ignored, no state change; request must be held by producer until in_ready.

Reset
REQ-030 rst_n low forces immediately, independent of clk: state IDLE, out_valid 0, Res 0, Hi 0, Zero 0, Overfl 0, DivZero 0, iteration counter 0.
REQ-031 Reset mid-BUSY or mid-DONE discards the operation; no result is ever presented for it.
REQ-032 in_ready = 1 from first rising edge after rst_n deasserts.

Verification
REQ-033 add A=0x7FFFFFFF B=0x00000001 -> Res 0x80000000, Overfl 1, out_valid one edge after acceptance; same with addu -> Overfl 0.
REQ-034 slt A=0xFFFFFFFF B=0x00000001 -> Res 1; sltu same operands -> Res 0, Zero 1.
REQ-035 mul A=0xFFFFFFFD B=0x00000007 -> Res 0xFFFFFFEB, Hi 0xFFFFFFFF, out_valid exactly 33 edges after acceptance; mulu A=0xFFFFFFFF B=2 -> Res 0xFFFFFFFE, Hi 1.
REQ-036 div A=0xFFFFFFF9 (-7) B=2 -> Res 0xFFFFFFFD, Hi 0xFFFFFFFF; divu A=5 B=0 -> Res 0xFFFFFFFF, Hi 5, DivZero 1; div 0x80000000 / 0xFFFFFFFF -> Res 0x80000000, Hi 0.
REQ-037 out_ready held low 5 cycles in DONE with new in_valid pulses -> outputs unchanged, in_ready 0, no new acceptance; out_ready high -> IDLE next edge.
REQ-038 rst_n pulsed low in 10th BUSY cycle of div -> all outputs 0 asynchronously, out_valid never asserts for that op, in_ready 1 after release; repeat with WIDTH=8 for REQ-035 latency (9 edges).

Source files
------------

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (add/sub/logic/compare) complete on the accepting edge.
// Multiply (shift-add) and divide (restoring) run one iteration per cycle
// for WIDTH cycles on operand magnitudes, then fix the signs.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only in IDLE)
//   A, B, ALUctr      operands and opcode, latched on acceptance
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   Res, Hi           primary result and high half / remainder
//   Zero, Overfl, DivZero  result flags
// ---------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Res,
   output logic [WIDTH-1:0] Hi,
   output logic             Zero,
   output logic             Overfl,
   output logic             DivZero
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam int            CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   logic [1:0]       state_r, state_nx_s;
   logic             in_ready_r, out_valid_r;
   logic [WIDTH-1:0] res_r, hi_r;
   logic             zero_r, ovf_r, dz_r;
   logic [CW-1:0]    cnt_r;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r;
   // acc_r: running high half (mul) or partial remainder (div)
   // lo_r : multiplier bits (mul) or dividend/quotient bits (div)
   // opnd_r: multiplicand (mul) or divisor (div), both as magnitudes
   logic [WIDTH-1:0] acc_r, lo_r, opnd_r;
   logic             neg_q_r, neg_r_r, bz_r;

   logic             accept_s, multi_s, signed_s;
   logic [WIDTH-1:0] mag_a_s, mag_b_s;
   logic [WIDTH-1:0] sum_s, dif_s, sc_res_s;
   logic             sc_ovf_s;

   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_rs_s;
   logic [WIDTH-1:0]   div_df_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   iter_hi_s, iter_lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;
   logic [WIDTH-1:0]   fin_res_s, fin_hi_s;
   logic               fin_dz_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign Res       = res_r;
   assign Hi        = hi_r;
   assign Zero      = zero_r;
   assign Overfl    = ovf_r;
   assign DivZero   = dz_r;

   assign accept_s = in_valid & in_ready_r & (state_r == ST_IDLE);
   assign multi_s  = ALUctr[3] & ALUctr[2];
   assign signed_s = ALUctr[0];
   assign mag_a_s  = (signed_s && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
   assign mag_b_s  = (signed_s && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;
   assign sum_s    = A + B;
   assign dif_s    = A - B;

   // Next-state logic of the IDLE/BUSY/DONE controller.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = multi_s ? ST_BUSY : ST_DONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_r == LAST_ITER) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Single-cycle result and signed-overflow detection from the live inputs.
   always_comb begin
      sc_res_s = {WIDTH{1'b0}};
      sc_ovf_s = 1'b0;
      case (ALUctr)
         4'b0000: begin
            sc_res_s = sum_s;
            sc_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0001: sc_res_s = sum_s;
         4'b0010: begin
            sc_res_s = dif_s;
            sc_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (dif_s[WIDTH-1] != A[WIDTH-1]);
         end
         4'b0011: sc_res_s = dif_s;
         4'b0100: sc_res_s = A & B;
         4'b0101: sc_res_s = A | B;
         4'b0110: sc_res_s = A ^ B;
         4'b0111: sc_res_s = ~(A | B);
         4'b1010: sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         4'b1011: sc_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
         default: sc_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One shift-add or restoring-divide iteration on the magnitude registers.
   always_comb begin
      mul_sum_s = {1'b0, acc_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
      div_rs_s  = {acc_r, lo_r[WIDTH-1]};
      div_ge_s  = (div_rs_s >= {1'b0, opnd_r});
      // When the subtraction succeeds the difference is below the divisor,
      // so the low WIDTH bits hold it exactly.
      div_df_s  = div_rs_s[WIDTH-1:0] - opnd_r;
      if (op_r[1]) begin
         if (div_ge_s) begin
            iter_hi_s = div_df_s;
            iter_lo_s = {lo_r[WIDTH-2:0], 1'b1};
         end else begin
            iter_hi_s = div_rs_s[WIDTH-1:0];
            iter_lo_s = {lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         iter_hi_s = mul_sum_s[WIDTH:1];
         iter_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end
   end

   // Sign correction and divide-by-zero override applied on the final iteration.
   always_comb begin
      prod_s     = {iter_hi_s, iter_lo_s};
      prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
      quo_fix_s  = neg_q_r ? ({WIDTH{1'b0}} - iter_lo_s) : iter_lo_s;
      rem_fix_s  = neg_r_r ? ({WIDTH{1'b0}} - iter_hi_s) : iter_hi_s;
      if (op_r[1]) begin
         if (bz_r) begin
            fin_res_s = {WIDTH{1'b1}};
            fin_hi_s  = a_r;
            fin_dz_s  = 1'b1;
         end else begin
            fin_res_s = quo_fix_s;
            fin_hi_s  = rem_fix_s;
            fin_dz_s  = 1'b0;
         end
      end else begin
         fin_res_s = prod_fix_s[WIDTH-1:0];
         fin_hi_s  = prod_fix_s[2*WIDTH-1:WIDTH];
         fin_dz_s  = 1'b0;
      end
   end

   // Controller, operand capture, iteration datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         res_r       <= {WIDTH{1'b0}};
         hi_r        <= {WIDTH{1'b0}};
         zero_r      <= 1'b0;
         ovf_r       <= 1'b0;
         dz_r        <= 1'b0;
         cnt_r       <= {CW{1'b0}};
         op_r        <= 4'b0000;
         a_r         <= {WIDTH{1'b0}};
         acc_r       <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         opnd_r      <= {WIDTH{1'b0}};
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         bz_r        <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         in_ready_r  <= (state_nx_s == ST_IDLE);
         out_valid_r <= (state_nx_s == ST_DONE);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  op_r  <= ALUctr;
                  a_r   <= A;
                  cnt_r <= {CW{1'b0}};
                  if (multi_s) begin
                     acc_r   <= {WIDTH{1'b0}};
                     neg_q_r <= signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_r_r <= signed_s & A[WIDTH-1];
                     bz_r    <= (B == {WIDTH{1'b0}});
                     if (ALUctr[1]) begin
                        lo_r   <= mag_a_s;
                        opnd_r <= mag_b_s;
                     end else begin
                        lo_r   <= mag_b_s;
                        opnd_r <= mag_a_s;
                     end
                  end else begin
                     res_r  <= sc_res_s;
                     hi_r   <= {WIDTH{1'b0}};
                     zero_r <= (sc_res_s == {WIDTH{1'b0}});
                     ovf_r  <= sc_ovf_s;
                     dz_r   <= 1'b0;
                  end
               end
            end
            ST_BUSY: begin
               acc_r <= iter_hi_s;
               lo_r  <= iter_lo_s;
               if (cnt_r == LAST_ITER) begin
                  cnt_r  <= {CW{1'b0}};
                  res_r  <= fin_res_s;
                  hi_r   <= fin_hi_s;
                  zero_r <= (fin_res_s == {WIDTH{1'b0}});
                  ovf_r  <= 1'b0;
                  dz_r   <= fin_dz_s;
               end else begin
                  cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- scoreboard bench for alu_mc.
// A driver issues requests and pushes the model's expected response; monitor
// processes compare every presented result against the queue head and pop it
// on the output handshake. Latency is counted in rising edges, the accepting
// edge being edge 1. A second WIDTH=8 instance covers the narrow latency.
// ---------------------------------------------------------------------------
module tb_alu_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  A, B, Res, Hi;
   logic [3:0]    ALUctr;
   logic          Zero, Overfl, DivZero;

   logic          iv8, ir8, ov8, or8;
   logic [7:0]    a8, b8, res8, hi8;
   logic [3:0]    op8;
   logic          zero8, ovf8, dz8;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .ALUctr(ALUctr), .out_valid(out_valid), .out_ready(out_ready),
      .Res(Res), .Hi(Hi), .Zero(Zero), .Overfl(Overfl), .DivZero(DivZero));

   alu_mc #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .A(a8), .B(b8), .ALUctr(op8), .out_valid(ov8), .out_ready(or8),
      .Res(res8), .Hi(hi8), .Zero(zero8), .Overfl(ovf8), .DivZero(dz8));

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z, ov, dz;
      int           lat;
      int           acc;
      int           id;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   next_id  = 1;
   int   rdy_mode = 0;   // 0 random, 1 hold low, 2 hold high

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: plain wide arithmetic on the opcode's meaning.
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t          e;
      longint        sa, sb, t, r;
      longint        smax, smin;
      logic [2*W-1:0] p;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      e.res = '0; e.hi = '0; e.ov = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0; e.id = 0;
      case (op)
         4'd0:  begin t = sa + sb; e.res = a + b; e.ov = (t > smax) || (t < smin); end
         4'd1:  e.res = a + b;
         4'd2:  begin t = sa - sb; e.res = a - b; e.ov = (t > smax) || (t < smin); end
         4'd3:  e.res = a - b;
         4'd4:  e.res = a & b;
         4'd5:  e.res = a | b;
         4'd6:  e.res = a ^ b;
         4'd7:  e.res = ~(a | b);
         4'd10: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
         4'd12: begin
            p = {32'd0, a} * {32'd0, b};
            e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
         end
         4'd13: begin
            t = sa * sb; p = t;
            e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = W + 1;
         end
         4'd14, 4'd15: begin
            e.lat = W + 1;
            if (b == '0) begin
               e.res = '1; e.hi = a; e.dz = 1'b1;
            end else if (op == 4'd14) begin
               e.res = a / b; e.hi = a % b;
            end else begin
               t = sa / sb; r = sa % sb;
               e.res = t[W-1:0]; e.hi = r[W-1:0];
            end
         end
         default: e.res = '0;
      endcase
      e.z = (e.res == '0);
      return e;
   endfunction

   // Compares presented outputs against the queue head every cycle they are valid.
   task automatic mon_neg();
      int lat_seen = 0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               if (q[0].id != lat_seen) begin
                  check("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                  lat_seen = q[0].id;
               end
               check("res", Res, q[0].res);
               check("hi", Hi, q[0].hi);
               check("zero", Zero, q[0].z);
               check("overfl", Overfl, q[0].ov);
               check("divzero", DivZero, q[0].dz);
               check("in_ready_in_done", in_ready, 1'b0);
            end
         end
      end
   endtask

   // Retires the head entry on the output handshake edge.
   task automatic mon_pos();
      forever begin
         @(posedge clk);
         if (rst_n && out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      end
   endtask

   task automatic rdy_gen();
      forever begin
         @(negedge clk);
         if (rdy_mode == 2)      out_ready = 1'b1;
         else if (rdy_mode == 1) out_ready = 1'b0;
         else                    out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
      int   n = 0;
      exp_t e;
      while (!in_ready && n < 300) begin @(negedge clk); n++; end
      if (!in_ready) begin
         check("ready_timeout", 64'd0, 64'd1);
         return;
      end
      rdy_mode = mode;
      e = model(op, a, b);
      e.acc = cyc + 1;
      e.id  = next_id++;
      q.push_back(e);
      in_valid = 1'b1; A = a; B = b; ALUctr = op;
      @(negedge clk);
      in_valid = 1'b0; A = $urandom; B = $urandom; ALUctr = 4'($urandom);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [7:0] eh, input logic eo, input logic ed, input int el);
      int n = 0;
      int acc;
      while (!ir8 && n < 100) begin @(negedge clk); n++; end
      op8 = op; a8 = a; b8 = b; iv8 = 1'b1; acc = cyc + 1;
      @(negedge clk);
      iv8 = 1'b0;
      n = 0;
      while (!ov8 && n < 100) begin @(negedge clk); n++; end
      check("w8_latency", 64'(cyc - acc + 1), 64'(el));
      check("w8_res", res8, er);
      check("w8_hi", hi8, eh);
      check("w8_zero", zero8, (er == 8'd0));
      check("w8_overfl", ovf8, eo);
      check("w8_divzero", dz8, ed);
      @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALUctr = 4'd0; out_ready = 1'b0;
      iv8 = 1'b0; a8 = 8'd0; b8 = 8'd0; op8 = 4'd0; or8 = 1'b1;
      fork
         mon_neg();
         mon_pos();
         rdy_gen();
      join_none

      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_res", Res, 32'd0);
      check("rst_hi", Hi, 32'd0);
      check("rst_flags", {Zero, Overfl, DivZero}, 3'b000);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1 check("ready_after_reset", in_ready, 1'b1);
      @(negedge clk);

      // Directed vectors from the block's worked examples.
      issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      issue(4'b0001, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      issue(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      issue(4'b1101, 32'hFFFF_FFFD, 32'h0000_0007, 0);
      issue(4'b1100, 32'hFFFF_FFFF, 32'h0000_0002, 0);
      issue(4'b1111, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(4'b1110, 32'h0000_0005, 32'h0000_0000, 0);
      issue(4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(4'b1000, 32'h1234_5678, 32'h0000_0001, 0);
      issue(4'b0010, 32'h8000_0000, 32'h0000_0001, 0);

      // Hold the result in DONE for five cycles while new requests pulse.
      issue(4'b1101, 32'($urandom), 32'($urandom), 1);
      n = 0;
      while (!out_valid && n < 60) begin @(negedge clk); n++; end
      check("hold_reached_done", out_valid, 1'b1);
      repeat (5) begin
         @(negedge clk);
         in_valid = 1'b1; A = $urandom; B = $urandom; ALUctr = 4'($urandom);
         check("hold_in_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rdy_mode = 2;
      @(negedge clk);
      @(posedge clk); #1;
      check("idle_after_release", {in_ready, out_valid}, 2'b10);
      rdy_mode = 0;
      @(negedge clk);

      for (int i = 0; i < 150; i++) issue(4'($urandom_range(0, 15)), pick(), pick(), 0);

      // Reset in the tenth BUSY cycle of a divide discards it.
      rdy_mode = 2;
      issue(4'b1111, 32'($urandom), 32'($urandom_range(1, 1000)), 2);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midbusy_rst_outs", {out_valid, Zero, Overfl, DivZero}, 4'b0000);
      check("midbusy_rst_res", Res, 32'd0);
      check("midbusy_rst_hi", Hi, 32'd0);
      q.delete();
      #10 rst_n = 1'b1;
      @(posedge clk); #1 check("ready_after_midbusy_reset", in_ready, 1'b1);
      repeat (40) @(negedge clk);
      check("discarded_never_valid", out_valid, 1'b0);
      rdy_mode = 0;

      for (int i = 0; i < 40; i++) issue(4'($urandom_range(0, 15)), pick(), pick(), 0);

      rdy_mode = 2;
      n = 0;
      while (q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
      check("drain_queue_empty", 64'(q.size()), 64'd0);

      // Narrow instance: latency WIDTH+1 = 9 for mul/div, 1 for single-cycle.
      run8(4'b1101, 8'hFD, 8'h07, 8'hEB, 8'hFF, 1'b0, 1'b0, 9);
      run8(4'b1100, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b0, 1'b0, 9);
      run8(4'b1111, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9);
      run8(4'b1110, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b0, 1'b1, 9);
      run8(4'b0000, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
